// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing with a branch delay slot and redirects, plus a hold buffer for stalls.
// Define FETCH_ADEL_CHECK_EN to flag and suppress misaligned fetches (adel); otherwise any address is read.
module fetch_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        adel
);

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

`ifdef FETCH_ADEL_CHECK_EN
  localparam bit ADEL_CHECK = 1'b1;
`else
  localparam bit ADEL_CHECK = 1'b0;
`endif

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  function automatic logic misaligned(input logic [1:0] lo);
    return ADEL_CHECK && (lo != 2'b00);
  endfunction

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        adel_q, adel_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  hold_state_e hold_state_q, hold_state_d;
  logic        hold_valid;
  logic [31:0] next_pc;

  assign hold_valid = (hold_state_q == HOLD_FULL);

  always_comb begin
    next_pc      = f_pc_q + 32'd4;
    f_pc_d       = f_pc_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    adel_d       = adel_q;
    if (flush) begin
      next_pc = flush_pc;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end

    // A flush beats a stall; during a plain stall the branch input is ignored.
    if (flush) begin
      f_pc_d       = flush_pc;
      inst_valid_d = 1'b0;
      adel_d       = 1'b0;
    end else if (!stall) begin
      f_pc_d       = next_pc;
      pc_d         = f_pc_q;
      inst_valid_d = 1'b1;
      adel_d       = misaligned(f_pc_q[1:0]);
    end
  end

  // The SRAM word for the presented pc is only valid in the first stall cycle, so grab it then.
  always_comb begin
    hold_state_d = hold_state_q;
    hold_inst_d  = hold_inst_q;
    case (hold_state_q)
      HOLD_EMPTY: begin
        if (stall && !flush) begin
          hold_state_d = HOLD_FULL;
          hold_inst_d  = inst_sram_rdata;
        end
      end
      HOLD_FULL: begin
        if (flush || !stall) begin
          hold_state_d = HOLD_EMPTY;
        end
      end
      default: hold_state_d = HOLD_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      f_pc_q       <= RESET_PC;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      adel_q       <= 1'b0;
      hold_inst_q  <= 32'h0;
      hold_state_q <= HOLD_EMPTY;
    end else begin
      f_pc_q       <= f_pc_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      adel_q       <= adel_d;
      hold_inst_q  <= hold_inst_d;
      hold_state_q <= hold_state_d;
    end
  end

  assign inst_sram_en   = resetn & ~stall & ~misaligned(f_pc_q[1:0]);
  assign inst_sram_addr = f_pc_q;
  assign pc             = pc_q;
  assign inst_valid     = inst_valid_q;
  assign adel           = adel_q;
  assign inst           = (!inst_valid_q || adel_q) ? 32'h0 :
                          (hold_valid ? hold_inst_q : inst_sram_rdata);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table walked cycle by cycle plus reset sequences.
// A simple SRAM model returns an address-derived word, or junk when not enabled.
module tb_fetch_stage;

  localparam logic [31:0] B = 32'hBFC00000;
`ifdef FETCH_ADEL_CHECK_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, stall, flush, branch_taken;
  logic [31:0] flush_pc, branch_target;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr, inst_sram_rdata;
  logic [31:0] pc, inst;
  logic        inst_valid, adel;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .pc              (pc),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .adel            (adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[7:0], a[15:8], a[23:16], a[31:24]} ^ 32'h0F0F1234;
  endfunction

  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= memw(inst_sram_addr);
    else              inst_sram_rdata <= 32'hDEADBEEF;
  end

  typedef struct {
    logic        stall, flush, br;
    logic [31:0] fpc, tgt;
    logic        e_en;
    logic [31:0] e_addr, e_pc;
    logic        e_valid, e_adel;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[0:31];
  int   nvec = 0;

  task automatic add(input logic s, input logic f, input logic [31:0] fp,
                     input logic b, input logic [31:0] t, input logic en,
                     input logic [31:0] addr, input logic [31:0] p,
                     input logic v, input logic ad);
    vecs[nvec].stall   = s;
    vecs[nvec].flush   = f;
    vecs[nvec].fpc     = fp;
    vecs[nvec].br      = b;
    vecs[nvec].tgt     = t;
    vecs[nvec].e_en    = en;
    vecs[nvec].e_addr  = addr;
    vecs[nvec].e_pc    = p;
    vecs[nvec].e_valid = v;
    vecs[nvec].e_adel  = ad;
    vecs[nvec].e_inst  = (v && !ad) ? memw(p) : 32'h0;
    nvec++;
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic chk_all(input int step, input logic en, input logic [31:0] addr,
                         input logic [31:0] p, input logic v, input logic ad,
                         input logic [31:0] ins);
    chk("en", step, {31'h0, inst_sram_en}, {31'h0, en});
    chk("addr", step, inst_sram_addr, addr);
    chk("pc", step, pc, p);
    chk("valid", step, {31'h0, inst_valid}, {31'h0, v});
    chk("adel", step, {31'h0, adel}, {31'h0, ad});
    chk("inst", step, inst, ins);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //  stall flush fpc        br  tgt          en     addr          pc            v  adel
    add(0, 0, 32'h0,         0, 32'h0,        1,     B,            B,            0, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     B+4,          B,            1, 0);
    add(1, 0, 32'h0,         0, 32'h0,        0,     B+8,          B+4,          1, 0);
    add(1, 0, 32'h0,         0, 32'h0,        0,     B+8,          B+4,          1, 0);
    add(1, 0, 32'h0,         0, 32'h0,        0,     B+8,          B+4,          1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     B+8,          B+4,          1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     B+32'hC,      B+8,          1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     B+32'h10,     B+32'hC,      1, 0);
    add(0, 0, 32'h0,         1, B+32'h100,    1,     B+32'h14,     B+32'h10,     1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     B+32'h100,    B+32'h14,     1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     B+32'h104,    B+32'h100,    1, 0);
    add(1, 0, 32'h0,         1, B+32'h200,    0,     B+32'h108,    B+32'h104,    1, 0);
    add(1, 0, 32'h0,         1, B+32'h200,    0,     B+32'h108,    B+32'h104,    1, 0);
    add(0, 0, 32'h0,         1, B+32'h200,    1,     B+32'h108,    B+32'h104,    1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     B+32'h200,    B+32'h108,    1, 0);
    add(1, 0, 32'h0,         0, 32'h0,        0,     B+32'h204,    B+32'h200,    1, 0);
    add(1, 1, B+32'h380,     0, 32'h0,        0,     B+32'h204,    B+32'h200,    1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     B+32'h380,    B+32'h200,    0, 0);
    add(0, 1, B+32'h500,     1, B+32'h600,    1,     B+32'h384,    B+32'h380,    1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     B+32'h500,    B+32'h380,    0, 0);
    add(0, 1, 32'hFFFFFFFC,  0, 32'h0,        1,     B+32'h504,    B+32'h500,    1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     32'hFFFFFFFC, B+32'h500,    0, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1,     32'h0,        32'hFFFFFFFC, 1, 0);
    add(0, 0, 32'h0,         1, B+32'h102,    1,     32'h4,        32'h0,        1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        !ADEL, B+32'h102,    32'h4,        1, 0);
    add(0, 0, 32'h0,         0, 32'h0,        !ADEL, B+32'h106,    B+32'h102,    1, ADEL);

    resetn = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    flush_pc = 32'h0; branch_target = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all(-1, 1'b0, B, B, 1'b0, 1'b0, 32'h0);

    resetn = 1'b1;
    for (int i = 0; i < nvec; i++) begin
      stall         = vecs[i].stall;
      flush         = vecs[i].flush;
      flush_pc      = vecs[i].fpc;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      #1;
      chk_all(i, vecs[i].e_en, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_valid,
              vecs[i].e_adel, vecs[i].e_inst);
      @(negedge clk);
    end

    // Reset arriving mid-stall with a redirect pending wins over everything.
    stall = 1'b1; flush = 1'b0; branch_taken = 1'b0;
    #1;
    @(negedge clk);
    resetn = 1'b0; flush = 1'b1; flush_pc = B + 32'h380;
    branch_taken = 1'b1; branch_target = B + 32'h700;
    #1;
    chk("rst_en", 100, {31'h0, inst_sram_en}, 32'h0);
    @(negedge clk);
    #1;
    chk_all(101, 1'b0, B, B, 1'b0, 1'b0, 32'h0);
    resetn = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    #1;
    chk_all(102, 1'b1, B, B, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_all(103, 1'b1, B + 32'h4, B, 1'b1, 1'b0, memw(B));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
